// File: rtl/dcache_write_buffer_if.sv
// Bus bundle between dcache, write buffer and the AXI switch write port.
interface dcache_write_buffer_if;
   logic         wb_push_i;
   logic [2:0]   wb_type_i;
   logic [31:0]  wb_addr_i;
   logic [3:0]   wb_wstrb_i;
   logic [127:0] wb_data_i;
   logic         wb_full_o;
   logic         wb_empty_o;
   logic [31:0]  rd_lookup_addr_i;
   logic         rd_hit_o;
   logic [127:0] rd_hit_data_o;
   logic         d_wr_req_o;
   logic [2:0]   d_wr_type_o;
   logic [31:0]  d_wr_addr_o;
   logic [3:0]   d_wr_wstrb_o;
   logic [127:0] d_wr_data_o;
   logic         d_wr_finish_i;

   modport slave (
      input  wb_push_i, wb_type_i, wb_addr_i, wb_wstrb_i, wb_data_i,
      input  rd_lookup_addr_i, d_wr_finish_i,
      output wb_full_o, wb_empty_o, rd_hit_o, rd_hit_data_o,
      output d_wr_req_o, d_wr_type_o, d_wr_addr_o, d_wr_wstrb_o, d_wr_data_o
   );

   modport master (
      output wb_push_i, wb_type_i, wb_addr_i, wb_wstrb_i, wb_data_i,
      output rd_lookup_addr_i, d_wr_finish_i,
      input  wb_full_o, wb_empty_o, rd_hit_o, rd_hit_data_o,
      input  d_wr_req_o, d_wr_type_o, d_wr_addr_o, d_wr_wstrb_o, d_wr_data_o
   );
endinterface

// File: rtl/dcache_write_buffer.sv
// FIFO write buffer draining dcache writes to the AXI switch, with line hazard lookup.
// Define WB_MERGE_EN to merge pushes into matching queued (not in-flight) entries.
module dcache_write_buffer #(
   parameter  int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic clk,
   input  logic reset,
   dcache_write_buffer_if.slave bus
);
   typedef enum logic {IDLE, BUSY} state_t;
   state_t state, state_nxt;

   logic             valid   [DEPTH];
   logic [2:0]       type_q  [DEPTH];
   logic [31:0]      addr_q  [DEPTH];
   logic [3:0]       wstrb_q [DEPTH];
   logic [127:0]     data_q  [DEPTH];
   logic [PTR_W-1:0] head, tail;
   logic [PTR_W:0]   count;

   logic full, busy, pop, alloc;
   logic unused_lookup_lsb;

   assign full = count == (PTR_W+1)'(DEPTH);
   assign busy = state == BUSY;
   assign pop  = busy && bus.d_wr_finish_i;
   assign unused_lookup_lsb = ^bus.rd_lookup_addr_i[3:0];

`ifdef WB_MERGE_EN
   logic             merge_hit;
   logic [PTR_W-1:0] merge_idx;

   // Oldest to youngest, so the last match is the youngest.
   always_comb begin
      logic [PTR_W-1:0] idx;
      merge_hit = 1'b0;
      merge_idx = '0;
      for (int i = 0; i < DEPTH; i++) begin
         idx = head + PTR_W'(i);
         if (bus.wb_push_i && valid[idx] &&
             !(busy && idx == head) &&
             addr_q[idx][31:4] == bus.wb_addr_i[31:4] &&
             type_q[idx] == bus.wb_type_i) begin
            merge_hit = 1'b1;
            merge_idx = idx;
         end
      end
   end

   assign alloc = bus.wb_push_i && !full && !merge_hit;
`else
   assign alloc = bus.wb_push_i && !full;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         for (int i = 0; i < DEPTH; i++) valid[i] <= 1'b0;
      end else begin
         if (pop) begin
            valid[head] <= 1'b0;
            head        <= head + PTR_W'(1);
         end
         if (alloc) begin
            valid[tail]   <= 1'b1;
            type_q[tail]  <= bus.wb_type_i;
            addr_q[tail]  <= bus.wb_addr_i;
            wstrb_q[tail] <= bus.wb_wstrb_i;
            data_q[tail]  <= bus.wb_data_i;
            tail          <= tail + PTR_W'(1);
         end
`ifdef WB_MERGE_EN
         if (merge_hit) begin
            data_q[merge_idx]  <= bus.wb_data_i;
            wstrb_q[merge_idx] <= (bus.wb_type_i == 3'b010)
                                ? (wstrb_q[merge_idx] | bus.wb_wstrb_i)
                                : bus.wb_wstrb_i;
         end
`endif
         if (alloc && !pop)
            count <= count + (PTR_W+1)'(1);
         else if (pop && !alloc)
            count <= count - (PTR_W+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Returning to IDLE after each finish guarantees a low req cycle.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (count != '0) state_nxt = BUSY;
         BUSY:    if (bus.d_wr_finish_i) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      bus.d_wr_req_o   = busy;
      bus.wb_full_o    = full;
      bus.wb_empty_o   = (count == '0) && !busy;
      bus.d_wr_type_o  = '0;
      bus.d_wr_addr_o  = '0;
      bus.d_wr_wstrb_o = '0;
      bus.d_wr_data_o  = '0;
      if (valid[head]) begin
         bus.d_wr_type_o  = type_q[head];
         bus.d_wr_addr_o  = addr_q[head];
         bus.d_wr_wstrb_o = wstrb_q[head];
         bus.d_wr_data_o  = data_q[head];
      end
   end

   always_comb begin
      logic [PTR_W-1:0] idx;
      bus.rd_hit_o      = 1'b0;
      bus.rd_hit_data_o = '0;
      for (int i = 0; i < DEPTH; i++) begin
         idx = head + PTR_W'(i);
         if (valid[idx] &&
             addr_q[idx][31:4] == bus.rd_lookup_addr_i[31:4]) begin
            bus.rd_hit_o      = 1'b1;
            bus.rd_hit_data_o = data_q[idx];
         end
      end
   end
endmodule

// File: tb/tb_dcache_write_buffer.sv
// Bench for dcache_write_buffer: vector table, directed sequences, random vs queue model.
module tb_dcache_write_buffer;
   localparam int DEPTH = 4;
   localparam logic [2:0] LT = 3'b100;
   localparam logic [2:0] WT = 3'b010;
   localparam logic [127:0] DA = {4{32'hA5A5A5A5}};
   localparam logic [127:0] D1 = {4{32'h11111111}};
   localparam logic [127:0] D2 = {4{32'h22222222}};

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   dcache_write_buffer_if bus();
   dcache_write_buffer #(.DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .bus(bus.slave)
   );

   int errors = 0;
   int checks = 0;

   typedef struct {
      bit           push;
      logic [2:0]   typ;
      logic [31:0]  addr;
      logic [127:0] data;
      bit           fin;
      logic [31:0]  look;
      bit           req;
      bit           full;
      bit           empty;
      bit           hit;
      logic [127:0] hdata;
      logic [31:0]  waddr;
   } vec_t;
   vec_t tbl[14];

   typedef struct {
      logic [2:0]   t;
      logic [31:0]  a;
      logic [3:0]   s;
      logic [127:0] d;
   } ent_t;
   ent_t mq[$];
   ent_t te;
   bit   mbusy, wasbusy;
   int   mi, pre;
   bit   rp, rf, e_hit;
   logic [2:0]   rt;
   logic [31:0]  ra, rl;
   logic [3:0]   rs;
   logic [127:0] rd, e_hd;
   logic [31:0]  eq[$];

   function automatic vec_t mk(bit p, logic [2:0] t, logic [31:0] a,
                               logic [127:0] d, bit f, logic [31:0] l,
                               bit rq, bit fu, bit em, bit h,
                               logic [127:0] hd, logic [31:0] wa);
      vec_t v;
      v.push = p; v.typ = t; v.addr = a; v.data = d; v.fin = f;
      v.look = l; v.req = rq; v.full = fu; v.empty = em; v.hit = h;
      v.hdata = hd; v.waddr = wa;
      return v;
   endfunction

   function automatic logic [127:0] dat(logic [31:0] a);
      return {a, ~a, a, 32'hC0DE0000};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [127:0] act,
                      input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic idle_in();
      bus.wb_push_i = 0;
      bus.wb_type_i = '0;
      bus.wb_addr_i = '0;
      bus.wb_wstrb_i = '0;
      bus.wb_data_i = '0;
      bus.rd_lookup_addr_i = '0;
      bus.d_wr_finish_i = 0;
   endtask

   task automatic do_reset();
      idle_in();
      reset = 1;
      tick();
      tick();
      reset = 0;
   endtask

   task automatic set_push(input logic [2:0] t, input logic [31:0] a,
                           input logic [127:0] d);
      bus.wb_push_i = 1;
      bus.wb_type_i = t;
      bus.wb_addr_i = a;
      bus.wb_wstrb_i = (t == LT) ? 4'hF : 4'h3;
      bus.wb_data_i = d;
   endtask

   task automatic push1(input logic [2:0] t, input logic [31:0] a,
                        input logic [127:0] d);
      set_push(t, a, d);
      tick();
      bus.wb_push_i = 0;
   endtask

   task automatic wait_req();
      for (int i = 0; i < 20 && bus.d_wr_req_o !== 1'b1; i++) tick();
      chk("req_wait", bus.d_wr_req_o, 1);
   endtask

   task automatic drain_one(input logic [31:0] a, input logic [127:0] d);
      wait_req();
      chk("head_addr", bus.d_wr_addr_o, a);
      chk("head_data", bus.d_wr_data_o, d);
      bus.d_wr_finish_i = 1;
      tick();
      bus.d_wr_finish_i = 0;
      chk("req_gap", bus.d_wr_req_o, 0);
   endtask

   initial begin
      tbl[0]  = mk(1, LT, 32'h1FC00040, DA, 0, 32'h1FC00040,
                   0, 0, 1, 0, 0, 0);
      tbl[1]  = mk(0, LT, 0, 0, 0, 32'h1FC0004C,
                   0, 0, 0, 1, DA, 32'h1FC00040);
      tbl[2]  = mk(0, LT, 0, 0, 0, 32'h1FC0004C,
                   1, 0, 0, 1, DA, 32'h1FC00040);
      tbl[3]  = mk(0, LT, 0, 0, 1, 32'h1FC0004C,
                   1, 0, 0, 1, DA, 32'h1FC00040);
      tbl[4]  = mk(0, LT, 0, 0, 0, 32'h1FC00040,
                   0, 0, 1, 0, 0, 0);
      tbl[5]  = mk(1, LT, 32'h100, D1, 0, 32'h10C,
                   0, 0, 1, 0, 0, 0);
      tbl[6]  = mk(1, WT, 32'h108, D2, 0, 32'h10C,
                   0, 0, 0, 1, D1, 32'h100);
      tbl[7]  = mk(0, LT, 0, 0, 0, 32'h10C,
                   1, 0, 0, 1, D2, 32'h100);
      tbl[8]  = mk(0, LT, 0, 0, 0, 32'h110,
                   1, 0, 0, 0, 0, 32'h100);
      tbl[9]  = mk(0, LT, 0, 0, 1, 32'h10C,
                   1, 0, 0, 1, D2, 32'h100);
      tbl[10] = mk(0, LT, 0, 0, 0, 32'h104,
                   0, 0, 0, 1, D2, 32'h108);
      tbl[11] = mk(0, LT, 0, 0, 0, 32'h104,
                   1, 0, 0, 1, D2, 32'h108);
      tbl[12] = mk(0, LT, 0, 0, 1, 32'h104,
                   1, 0, 0, 1, D2, 32'h108);
      tbl[13] = mk(0, LT, 0, 0, 0, 32'h104,
                   0, 0, 1, 0, 0, 0);

      do_reset();
      #1;
      chk("rst_full", bus.wb_full_o, 0);
      chk("rst_empty", bus.wb_empty_o, 1);
      chk("rst_req", bus.d_wr_req_o, 0);
      chk("rst_hit", bus.rd_hit_o, 0);
      chk("rst_hdata", bus.rd_hit_data_o, 0);
      chk("rst_type", bus.d_wr_type_o, 0);
      chk("rst_addr", bus.d_wr_addr_o, 0);
      chk("rst_wstrb", bus.d_wr_wstrb_o, 0);
      chk("rst_data", bus.d_wr_data_o, 0);

      for (int i = 0; i < 14; i++) begin
         bus.wb_push_i = tbl[i].push;
         bus.wb_type_i = tbl[i].typ;
         bus.wb_addr_i = tbl[i].addr;
         bus.wb_wstrb_i = (tbl[i].typ == LT) ? 4'hF : 4'h3;
         bus.wb_data_i = tbl[i].data;
         bus.d_wr_finish_i = tbl[i].fin;
         bus.rd_lookup_addr_i = tbl[i].look;
         #1;
         chk($sformatf("v%0d_req", i), bus.d_wr_req_o, tbl[i].req);
         chk($sformatf("v%0d_full", i), bus.wb_full_o, tbl[i].full);
         chk($sformatf("v%0d_empty", i), bus.wb_empty_o, tbl[i].empty);
         chk($sformatf("v%0d_hit", i), bus.rd_hit_o, tbl[i].hit);
         chk($sformatf("v%0d_hdata", i), bus.rd_hit_data_o, tbl[i].hdata);
         chk($sformatf("v%0d_waddr", i), bus.d_wr_addr_o, tbl[i].waddr);
         tick();
      end
      idle_in();

      // Fill to full, overflow push ignored, in-order drain.
      do_reset();
      for (int i = 0; i < 4; i++)
         push1(LT, 32'h400 + 32'(i) * 16, dat(32'h400 + 32'(i) * 16));
      chk("fill_full", bus.wb_full_o, 1);
      push1(LT, 32'h440, dat(32'h440));
      chk("ovf_full", bus.wb_full_o, 1);
      bus.rd_lookup_addr_i = 32'h440;
      #1;
      chk("ovf_miss", bus.rd_hit_o, 0);
      for (int i = 0; i < 4; i++)
         drain_one(32'h400 + 32'(i) * 16, dat(32'h400 + 32'(i) * 16));
      chk("fill_empty", bus.wb_empty_o, 1);

      // Push and pop together at count 2, across pointer wrap.
      do_reset();
      eq.delete();
      push1(LT, 32'h500, dat(32'h500));
      push1(LT, 32'h510, dat(32'h510));
      eq.push_back(32'h500);
      eq.push_back(32'h510);
      for (int k = 0; k < 6; k++) begin
         wait_req();
         chk("wrap_head", bus.d_wr_addr_o, eq[0]);
         set_push(LT, 32'h520 + 32'(k) * 16, dat(32'h520 + 32'(k) * 16));
         bus.d_wr_finish_i = 1;
         tick();
         bus.wb_push_i = 0;
         bus.d_wr_finish_i = 0;
         void'(eq.pop_front());
         eq.push_back(32'h520 + 32'(k) * 16);
         chk("wrap_gap", bus.d_wr_req_o, 0);
         chk("wrap_full", bus.wb_full_o, 0);
      end
      drain_one(eq[0], dat(eq[0]));
      drain_one(eq[1], dat(eq[1]));
      chk("wrap_empty", bus.wb_empty_o, 1);

      // Reset while a write is in flight.
      do_reset();
      push1(LT, 32'h600, D1);
      push1(LT, 32'h610, D1);
      push1(LT, 32'h620, D1);
      wait_req();
      reset = 1;
      tick();
      reset = 0;
      chk("rb_req", bus.d_wr_req_o, 0);
      chk("rb_empty", bus.wb_empty_o, 1);
      chk("rb_addr", bus.d_wr_addr_o, 0);
      for (int i = 0; i < 3; i++) begin
         bus.rd_lookup_addr_i = 32'h600 + 32'(i) * 16;
         #1;
         chk("rb_miss", bus.rd_hit_o, 0);
      end

      // Repeated push to the same line behind an in-flight head.
      do_reset();
      push1(LT, 32'h200, dat(32'h200));
      wait_req();
      push1(LT, 32'h300, D1);
      push1(LT, 32'h300, D2);
      bus.rd_lookup_addr_i = 32'h300;
      #1;
      chk("mg_hit", bus.rd_hit_data_o, D2);
      drain_one(32'h200, dat(32'h200));
`ifdef WB_MERGE_EN
      drain_one(32'h300, D2);
`else
      drain_one(32'h300, D1);
      drain_one(32'h300, D2);
`endif
      chk("mg_empty", bus.wb_empty_o, 1);

      // Random traffic against a queue model.
      do_reset();
      mq.delete();
      mbusy = 0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         rp = ($urandom_range(0, 1) == 1);
         rt = ($urandom_range(0, 1) == 1) ? LT : WT;
         ra = 32'h1000 + 32'($urandom_range(0, 7)) * 16
            + 32'($urandom_range(0, 3)) * 4;
         rs = 4'($urandom_range(1, 15));
         rd = {$urandom, $urandom, $urandom, $urandom};
         rf = ($urandom_range(0, 9) < 4);
         rl = 32'h1000 + 32'($urandom_range(0, 8)) * 16;
         bus.wb_push_i = rp;
         bus.wb_type_i = rt;
         bus.wb_addr_i = ra;
         bus.wb_wstrb_i = rs;
         bus.wb_data_i = rd;
         bus.d_wr_finish_i = rf;
         bus.rd_lookup_addr_i = rl;
         #1;
         e_hit = 0;
         e_hd = '0;
         foreach (mq[i])
            if (mq[i].a[31:4] == rl[31:4]) begin
               e_hit = 1;
               e_hd = mq[i].d;
            end
         chk("rnd_req", bus.d_wr_req_o, mbusy);
         chk("rnd_full", bus.wb_full_o, mq.size() == DEPTH);
         chk("rnd_empty", bus.wb_empty_o, mq.size() == 0 && !mbusy);
         chk("rnd_haddr", bus.d_wr_addr_o, mq.size() != 0 ? mq[0].a : 0);
         chk("rnd_hdat", bus.d_wr_data_o, mq.size() != 0 ? mq[0].d : 0);
         chk("rnd_hstrb", bus.d_wr_wstrb_o, mq.size() != 0 ? mq[0].s : 0);
         chk("rnd_hit", bus.rd_hit_o, e_hit);
         chk("rnd_hitd", bus.rd_hit_data_o, e_hd);
         mi = -1;
`ifdef WB_MERGE_EN
         if (rp)
            foreach (mq[i])
               if (!(mbusy && i == 0) && mq[i].a[31:4] == ra[31:4] &&
                   mq[i].t == rt)
                  mi = i;
`endif
         pre = mq.size();
         wasbusy = mbusy;
         if (mi >= 0) begin
            te = mq[mi];
            te.d = rd;
            te.s = (rt == WT) ? (te.s | rs) : rs;
            mq[mi] = te;
         end
         if (wasbusy && rf) void'(mq.pop_front());
         if (rp && mi < 0 && pre < DEPTH) begin
            te.t = rt;
            te.a = ra;
            te.s = rs;
            te.d = rd;
            mq.push_back(te);
         end
         mbusy = wasbusy ? !rf : (pre != 0);
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/dcache_write_buffer.md
Name: dcache_write_buffer

Overview:
- FIFO write buffer between the data cache and the d_wr_* port of Cache_AXI_switch.
- Queues dirty-line evictions and uncached stores so the data cache can refill without waiting for the AXI write.
- Drains one entry at a time using the switch's req/finish handshake.
- Provides a line-address hazard lookup so reads never bypass a pending write to the same line.

Parameters:
- DEPTH, 4, number of entries; power of two, ≥2.
- PTR_W, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- wb_push_i  in  1  enqueue request from dcache.
- wb_type_i  in  3  write type (3'b100 line, 3'b010 word).
- wb_addr_i  in  32  write address.
- wb_wstrb_i  in  4  byte strobes (word writes).
- wb_data_i  in  128  line data (word writes use [31:0]).
- wb_full_o  out  1  no free entry.
- wb_empty_o  out  1  no entries, drain idle.
- rd_lookup_addr_i  in  32  read address to check.
- rd_hit_o  out  1  a valid entry matches the lookup line.
- rd_hit_data_o  out  128  data of the youngest matching entry.
- d_wr_req_o  out  1  to switch d_wr_req_i.
- d_wr_type_o  out  3  head type.
- d_wr_addr_o  out  32  head address.
- d_wr_wstrb_o  out  4  head strobes.
- d_wr_data_o  out  128  head data.
- d_wr_finish_i  in  1  from switch d_wr_finish_o; current write done.

Behaviour:
- Storage: DEPTH entries {valid, type, addr, wstrb, data}, plus head pointer, tail pointer and count[PTR_W:0].
- Reset (synchronous, clk edge with reset=1):
  - All valid bits cleared; pointers and count = 0; state = IDLE.
  - Outputs: wb_full_o=0, wb_empty_o=1, d_wr_req_o=0, rd_hit_o=0, rd_hit_data_o=0.
  - d_wr_type/addr/wstrb/data_o = 0 while empty.
  - Reset mid-drain abandons the in-flight write; the switch is reset with it.
- Push:
  - Accepted when wb_push_i=1 and wb_full_o=0 at the edge. The entry is written at the tail, tail wraps modulo DEPTH, count+1.
  - Push while full is ignored (no state change). Upstream must hold until !wb_full_o.
- Full and empty flags:
  - wb_full_o = (count==DEPTH), registered-state decode. A pop in the same cycle does not make room for that cycle's push.
  - wb_empty_o = (count==0) && state==IDLE.
- Drain FSM:
  - IDLE: if count!=0, go to BUSY.
  - BUSY: d_wr_req_o=1 and the head fields are driven stably. On d_wr_finish_i=1: clear head valid, head+1 (wraps), count-1, go to IDLE.
  - d_wr_req_o is low for at least one cycle between consecutive writes.
  - d_wr_finish_i sampled in IDLE is ignored.
- Latency: push at edge k → d_wr_req_o high after edge k+1 (buffer previously empty).
- Simultaneous push and pop: count unchanged, both pointers advance.
- Head fields never change while BUSY.
- Hazard lookup (combinational):
  - Compare rd_lookup_addr_i[31:4] against addr[31:4] of every valid entry, including the in-flight head.
  - rd_hit_o = any match. rd_hit_data_o = data of the youngest match (nearest to tail), else 0.
  - A same-cycle push is not visible to the lookup.
- Flush/stall: none. Buffered writes are architecturally committed and are never dropped.

Optional Feature:
- WB_MERGE_EN defined: a push whose addr[31:4] and type match a valid entry that is not the in-flight head overwrites that entry in place.
  - data is replaced; wstrb is ORed for word type.
  - count and tail are unchanged. The merge is accepted even when full.
  - The youngest matching entry wins.
- Undefined: every accepted push allocates a new entry; there is no merge logic.

Test Plan:
- Reset, then one line push addr 0x1FC0_0040, data 128'hA5…: d_wr_req_o rises 2 edges later with matching fields; finish pulse → wb_empty_o=1 one cycle later.
- Push 4 entries with finish held low: wb_full_o=1; 5th push ignored. Finish releases entries in order 0→3 with ≥1 idle cycle between reqs.
- Push and finish in the same cycle at count=2: count stays 2, FIFO order preserved across pointer wrap (≥DEPTH+2 total entries).
- Entries at 0x100 (data D1) and 0x108 (data D2), lookup 0x10C: rd_hit_o=1, rd_hit_data_o=D2. Lookup 0x110: rd_hit_o=0, data 0.
- Assert reset while BUSY with 3 entries: next cycle d_wr_req_o=0, wb_empty_o=1, a lookup of any pushed address misses.
- WB_MERGE_EN: head 0x200 in flight, push 0x300 then 0x300 again with new data: count=2 (not 3), drained data at 0x300 equals the second push. Without the macro, count=3.
